// File: rtl/wb_cmd_master.sv
// Wishbone classic single-cycle initiator: turns one write/read/poll command
// into bus cycles and returns exactly one response per command.
module wb_cmd_master #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int POLL_GAP       = 4,
  parameter int MAX_POLLS      = 1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  input  logic [31:0] cmd_mask_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic [1:0]  rsp_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  // cyc must drop for at least one cycle between poll reads, even with no gap.
  localparam int GAP_LEN = (POLL_GAP < 1) ? 1 : POLL_GAP;
  localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW      = $clog2(GAP_LEN + 1);
  localparam int PW      = $clog2(MAX_POLLS + 1);

  localparam logic [1:0] OP_WRITE      = 2'b00;
  localparam logic [1:0] OP_READ       = 2'b01;
  localparam logic [1:0] OP_POLL       = 2'b10;
  localparam logic [1:0] ERR_OK        = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT   = 2'b01;
  localparam logic [1:0] ERR_EXHAUSTED = 2'b10;
  localparam logic [1:0] ERR_BADOP     = 2'b11;

  typedef enum logic [1:0] {IDLE, BUS, GAP, RESP} state_t;

  state_t         state_q, state_d;
  logic           cmd_ready_q, cmd_ready_d;
  logic           cyc_q, cyc_d;
  logic           we_q, we_d;
  logic [3:0]     sel_q, sel_d;
  logic [31:0]    adr_q, adr_d;
  logic [31:0]    dat_q, dat_d;
  logic [1:0]     op_q, op_d;
  logic [31:0]    mask_q, mask_d;
  logic [TW-1:0]  t_q, t_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic [PW-1:0]  polls_q, polls_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [31:0]    rsp_dat_q, rsp_dat_d;
  logic [1:0]     rsp_err_q, rsp_err_d;

  logic [PW-1:0]  polls_inc;
  logic           poll_match;

  assign polls_inc  = polls_q + PW'(1);
  assign poll_match = ((wbm_dat_i & mask_q) == (dat_q & mask_q));

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    op_d        = op_q;
    mask_d      = mask_q;
    t_d         = t_q;
    gap_d       = gap_q;
    polls_d     = polls_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          if (cmd_op_i == ERR_BADOP) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = ERR_BADOP;
            rsp_dat_d   = '0;
          end else begin
            state_d = BUS;
            cyc_d   = 1'b1;
            we_d    = (cmd_op_i == OP_WRITE);
            op_d    = cmd_op_i;
            adr_d   = cmd_adr_i;
            dat_d   = cmd_dat_i;
            sel_d   = cmd_sel_i;
            mask_d  = cmd_mask_i;
            t_d     = TW'(1);
            polls_d = '0;
          end
        end
      end

      BUS: begin
        // An ack on the final allowed cycle still completes the access.
        if (wbm_ack_i) begin
          cyc_d = 1'b0;
          if (op_q == OP_POLL) begin
            if (poll_match) begin
              state_d     = RESP;
              rsp_valid_d = 1'b1;
              rsp_err_d   = ERR_OK;
              rsp_dat_d   = wbm_dat_i;
            end else if (polls_inc == PW'(MAX_POLLS)) begin
              state_d     = RESP;
              rsp_valid_d = 1'b1;
              rsp_err_d   = ERR_EXHAUSTED;
              rsp_dat_d   = wbm_dat_i;
            end else begin
              state_d = GAP;
              polls_d = polls_inc;
              gap_d   = GW'(1);
            end
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = ERR_OK;
            rsp_dat_d   = (op_q == OP_READ) ? wbm_dat_i : 32'h0;
          end
        end else if (t_q == TW'(TIMEOUT_CYCLES)) begin
          cyc_d       = 1'b0;
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_TIMEOUT;
          rsp_dat_d   = '0;
        end else begin
          t_d = t_q + TW'(1);
        end
      end

      GAP: begin
        if (gap_q == GW'(GAP_LEN)) begin
          state_d = BUS;
          cyc_d   = 1'b1;
          t_d     = TW'(1);
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      RESP: begin
        if (rsp_ready_i) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
        cyc_d       = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      op_q        <= '0;
      mask_q      <= '0;
      t_q         <= '0;
      gap_q       <= '0;
      polls_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      op_q        <= op_d;
      mask_q      <= mask_d;
      t_q         <= t_d;
      gap_q       <= gap_d;
      polls_q     <= polls_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = we_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: scripted Wishbone slave, expected
// responses queued at issue time and popped when the DUT responds.
module tb_wb_cmd_master;

  localparam int TMO  = 8;
  localparam int GAPN = 4;
  localparam int MAXP = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_adr, cmd_dat, cmd_mask;
  logic [3:0]  cmd_sel;
  logic        rsp_valid_o;
  logic        rsp_ready;
  logic [31:0] rsp_dat_o;
  logic [1:0]  rsp_err_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic        wbm_ack;
  logic [31:0] wbm_dat_in;

  wb_cmd_master #(.TIMEOUT_CYCLES(TMO), .POLL_GAP(GAPN), .MAX_POLLS(MAXP)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel), .cmd_mask_i(cmd_mask),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_ack_i(wbm_ack), .wbm_dat_i(wbm_dat_in)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct { logic [31:0] dat; logic [1:0] err; } rsp_t;
  rsp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int accept_edge, rsp_edge;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  // Slave model configuration and per-command statistics
  int          ack_wait = 0;     // wait cycles before ack; -1 never acks
  bit          stray_ack = 1'b0; // drive ack while cyc is low
  logic [31:0] rd_q[$];
  int          stb_n, acks_n, gap_run;
  int          gaps[$];
  bit          in_access = 1'b0, unstable;
  logic [31:0] acc_adr, acc_dat;
  logic [3:0]  acc_sel;
  logic        acc_we;
  int          wait_n;

  initial begin
    wbm_ack = 1'b0;
    wbm_dat_in = '0;
    forever begin
      @(negedge clk);
      if (wbm_cyc_o && wbm_stb_o) begin
        if (!in_access) begin
          in_access = 1'b1;
          acc_adr = wbm_adr_o; acc_dat = wbm_dat_o; acc_sel = wbm_sel_o; acc_we = wbm_we_o;
          wait_n = 0;
          if (acks_n > 0) gaps.push_back(gap_run);
        end else if (wbm_adr_o !== acc_adr || wbm_dat_o !== acc_dat ||
                     wbm_sel_o !== acc_sel || wbm_we_o !== acc_we) begin
          unstable = 1'b1;
        end
        stb_n++;
        gap_run = 0;
        if (ack_wait >= 0 && wait_n == ack_wait) begin
          wbm_ack = 1'b1;
          wbm_dat_in = (rd_q.size() > 0) ? rd_q.pop_front() : ($urandom | 32'h1);
          acks_n++;
        end else begin
          wbm_ack = 1'b0;
          wbm_dat_in = $urandom;
          wait_n++;
        end
      end else begin
        in_access = 1'b0;
        gap_run++;
        wbm_ack = stray_ack;
        wbm_dat_in = $urandom;
      end
    end
  end

  task automatic new_cmd();
    stb_n = 0; acks_n = 0; gap_run = 0; unstable = 1'b0;
    gaps.delete();
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [31:0] mask,
                       input logic [31:0] exp_dat, input logic [1:0] exp_err, input bit expect_rsp);
    rsp_t e;
    bit ok, rdy;
    if (expect_rsp) begin
      e.dat = exp_dat; e.err = exp_err;
      exp_q.push_back(e);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_mask = mask;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      rdy = cmd_ready_o;
      @(negedge clk);
      if (rdy) begin ok = 1'b1; accept_edge = edge_cnt; break; end
    end
    cmd_valid = 1'b0;
    chk("cmd_accept", 64'(ok), 64'(1));
  endtask

  task automatic collect(input int stall, input string tag);
    rsp_t e;
    int waited = 0;
    while (!rsp_valid_o && waited < 300) begin @(negedge clk); waited++; end
    chk({tag, "_valid"}, 64'(rsp_valid_o), 64'(1));
    chk({tag, "_sb_nonempty"}, 64'(exp_q.size() > 0), 64'(1));
    if (!rsp_valid_o || exp_q.size() == 0) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      return;
    end
    e = exp_q.pop_front();
    rsp_edge = edge_cnt;
    chk({tag, "_cyc_off"}, 64'(wbm_cyc_o), 64'(0));
    repeat (stall) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 64'(rsp_valid_o), 64'(1));
      chk({tag, "_hold_dat"}, 64'(rsp_dat_o), 64'(e.dat));
    end
    chk({tag, "_dat"}, 64'(rsp_dat_o), 64'(e.dat));
    chk({tag, "_err"}, 64'(rsp_err_o), 64'(e.err));
    $display("rsp %s: dat=0x%08h err=%0d stb_cycles=%0d reads=%0d", tag, rsp_dat_o, rsp_err_o, stb_n, acks_n);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_drop"}, 64'(rsp_valid_o), 64'(0));
    chk({tag, "_ready"}, 64'(cmd_ready_o), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int vis;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_adr = '0; cmd_dat = '0;
    cmd_sel = '0; cmd_mask = '0; rsp_ready = 1'b0;
    new_cmd();
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(cmd_ready_o), 64'(1));
    chk("rst_ctl", 64'({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, rsp_valid_o, rsp_err_o}), 64'(0));
    chk("rst_adr", 64'(wbm_adr_o), 64'(0));
    chk("rst_wdat", 64'(wbm_dat_o), 64'(0));
    chk("rst_rdat", 64'(rsp_dat_o), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Write, ack on first stb cycle: response registered one edge after stb edge
    new_cmd(); ack_wait = 0;
    issue(2'b00, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 32'h0, 32'h0, 2'b00, 1'b1);
    collect(0, "wr");
    chk("wr_latency_edges", 64'(rsp_edge - accept_edge), 64'(1));
    chk("wr_stb_cycles", 64'(stb_n), 64'(1));
    chk("wr_we", 64'(acc_we), 64'(1));
    chk("wr_adr", 64'(acc_adr), 64'(32'h3000_0004));
    chk("wr_bus_dat", 64'(acc_dat), 64'(32'hDEAD_BEEF));
    chk("wr_sel", 64'(acc_sel), 64'(4'hF));

    // Read with 3 wait states, response stalled 3 cycles
    new_cmd(); ack_wait = 3; rd_q.push_back(32'h1234_5678);
    issue(2'b01, 32'h3000_0010, 32'h0, 4'hF, 32'h0, 32'h1234_5678, 2'b00, 1'b1);
    collect(3, "rd");
    chk("rd_stb_cycles", 64'(stb_n), 64'(4));
    chk("rd_stable", 64'(unstable), 64'(0));
    chk("rd_we", 64'(acc_we), 64'(0));
    chk("rd_adr", 64'(acc_adr), 64'(32'h3000_0010));

    // Read timeout, then ack on the last permitted cycle
    new_cmd(); ack_wait = -1;
    issue(2'b01, 32'h3000_0020, 32'h0, 4'h3, 32'h0, 32'h0, 2'b01, 1'b1);
    collect(0, "tmo");
    chk("tmo_stb_cycles", 64'(stb_n), 64'(TMO));
    chk("tmo_stable", 64'(unstable), 64'(0));
    new_cmd(); ack_wait = TMO - 1; rd_q.push_back(32'hCAFE_0008);
    issue(2'b01, 32'h3000_0024, 32'h0, 4'hF, 32'h0, 32'hCAFE_0008, 2'b00, 1'b1);
    collect(0, "tmo_edge");
    chk("tmo_edge_stb_cycles", 64'(stb_n), 64'(TMO));

    // Poll matching on third read; stray acks while cyc is low must be ignored
    new_cmd(); ack_wait = 0; stray_ack = 1'b1;
    rd_q.push_back(32'h0); rd_q.push_back(32'hFFFF_FFFE); rd_q.push_back(32'h1);
    issue(2'b10, 32'h3000_0100, 32'h1, 4'hF, 32'h1, 32'h1, 2'b00, 1'b1);
    collect(0, "poll");
    stray_ack = 1'b0;
    chk("poll_reads", 64'(acks_n), 64'(3));
    chk("poll_gap_count", 64'(gaps.size()), 64'(2));
    foreach (gaps[i]) chk("poll_gap_len", 64'(gaps[i]), 64'(GAPN));
    chk("poll_we", 64'(acc_we), 64'(0));

    // Poll where only masked bits decide the match
    new_cmd(); ack_wait = 2; rd_q.push_back(32'h0000_1234);
    issue(2'b10, 32'h3000_0104, 32'hFFFF_12FF, 4'hF, 32'h0000_FF00, 32'h0000_1234, 2'b00, 1'b1);
    collect(0, "poll_mask");
    chk("poll_mask_reads", 64'(acks_n), 64'(1));

    // Poll never matching: exhausted after MAX_POLLS reads
    new_cmd(); ack_wait = 1;
    rd_q.push_back(32'h0); rd_q.push_back(32'h1); rd_q.push_back(32'h2); rd_q.push_back(32'h3);
    issue(2'b10, 32'h3000_0108, 32'h5, 4'hF, 32'hF, 32'h3, 2'b10, 1'b1);
    collect(0, "poll_exh");
    rd_q.delete();
    chk("poll_exh_reads", 64'(acks_n), 64'(MAXP));
    chk("poll_exh_stb_cycles", 64'(stb_n), 64'(2 * MAXP));
    chk("poll_exh_gap_count", 64'(gaps.size()), 64'(MAXP - 1));
    foreach (gaps[i]) chk("poll_exh_gap_len", 64'(gaps[i]), 64'(GAPN));

    // Reserved opcode: no bus cycle, error response held across stall
    new_cmd(); ack_wait = 0;
    issue(2'b11, 32'h3000_0200, 32'h1, 4'hF, 32'h0, 32'h0, 2'b11, 1'b1);
    collect(2, "badop");
    chk("badop_stb_cycles", 64'(stb_n), 64'(0));

    // Reset in the middle of a strobe: bus dropped, no response appears
    new_cmd(); ack_wait = -1;
    issue(2'b01, 32'h3000_0040, 32'h0, 4'hF, 32'h0, 32'h0, 2'b00, 1'b0);
    repeat (2) @(negedge clk);
    chk("mid_stb_active", 64'(wbm_stb_o), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ctl", 64'({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, rsp_valid_o, rsp_err_o}), 64'(0));
    chk("mid_rst_adr", 64'(wbm_adr_o), 64'(0));
    chk("mid_rst_ready", 64'(cmd_ready_o), 64'(1));
    vis = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid_o || wbm_cyc_o) vis++;
    end
    chk("mid_rst_quiet", 64'(vis), 64'(0));
    $display("rsp mid_rst: no response issued");

    // Recovery read after reset
    new_cmd(); ack_wait = 0; rd_q.push_back(32'h55AA_33CC);
    issue(2'b01, 32'h3000_0044, 32'h0, 4'hF, 32'h0, 32'h55AA_33CC, 2'b00, 1'b1);
    collect(1, "recover");

    chk("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
